// File: rtl/tournament_bp.sv
// Tournament branch-direction predictor: gshare + two-level local, arbitrated by a 2-bit chooser.
// Latency: prediction is combinational from f_pc; history shift, training and repair land on the next clk edge.
// Backpressure: none; every cycle accepts a fetch lookup, a D-stage history shift and one M-stage resolution.
module tournament_bp #(
    parameter  int GPHT_IDX_W = 8,
    parameter  int GHR_W      = 8,
    parameter  int LHT_IDX_W  = 4,
    parameter  int LHR_W      = 6,
    parameter  int CPHT_IDX_W = 8,
    localparam int META_W     = GHR_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [31:0]       f_pc,
    output logic              f_pred_taken,
    output logic [META_W-1:0] f_meta,
    input  logic              d_branch,
    input  logic              d_pred_taken,
    input  logic              r_valid,
    input  logic [31:0]       r_pc,
    input  logic              r_taken,
    input  logic [META_W-1:0] r_meta,
    output logic              mispredict
);

    localparam int GPHT_N = 1 << GPHT_IDX_W;
    localparam int LHT_N  = 1 << LHT_IDX_W;
    localparam int LPHT_N = 1 << LHR_W;
    localparam int CPHT_N = 1 << CPHT_IDX_W;

    // Bit positions of the prediction flags inside the metadata word;
    // the GHR snapshot occupies everything above them.
    localparam int META_FINAL  = 0;
    localparam int META_LOCAL  = 1;
    localparam int META_GLOBAL = 2;

    typedef logic [1:0] ctr_t;

    // Weakly not-taken: one taken outcome is enough to flip the prediction.
    localparam ctr_t CTR_INIT = 2'b01;

    localparam logic [1:0] MODE_TOURNAMENT = 2'b00;
    localparam logic [1:0] MODE_GLOBAL     = 2'b01;
    localparam logic [1:0] MODE_LOCAL      = 2'b10;

    // Elaboration-time guard on parameter combinations the indexing relies on.
    if (GHR_W > GPHT_IDX_W || GHR_W < 2) begin : g_bad_ghr_w
        $error("tournament_bp: GHR_W must be in [2, GPHT_IDX_W]");
    end

    // Saturating 2-bit counter step toward the given direction.
    function automatic ctr_t ctr_train(input ctr_t c, input logic up);
        ctr_t n;
        n = c;
        if (up && (c != 2'b11)) begin
            n = c + 2'd1;
        end else if (!up && (c != 2'b00)) begin
            n = c - 2'd1;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctr_t             gpht_q [GPHT_N];
    ctr_t             lpht_q [LPHT_N];
    ctr_t             cpht_q [CPHT_N];
    logic [LHR_W-1:0] lht_q  [LHT_N];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [GPHT_IDX_W-1:0] f_g_idx;
    logic [LHT_IDX_W-1:0]  f_l_idx;
    logic [LHR_W-1:0]      f_lhist;
    logic [CPHT_IDX_W-1:0] f_c_idx;
    logic                  f_gpred;
    logic                  f_lpred;
    logic                  f_cpick_local;
    logic                  f_final;

    assign f_g_idx       = f_pc[GPHT_IDX_W+1:2] ^ GPHT_IDX_W'(ghr_q);
    assign f_l_idx       = f_pc[LHT_IDX_W+1:2];
    assign f_lhist       = lht_q[f_l_idx];
    assign f_c_idx       = f_pc[CPHT_IDX_W+1:2];
    assign f_gpred       = gpht_q[f_g_idx][1];
    assign f_lpred       = lpht_q[f_lhist][1];
    assign f_cpick_local = cpht_q[f_c_idx][1];

    // Final direction chosen by the operating mode; 11 forces static not-taken.
    always_comb begin
        f_final = 1'b0;
        case (mode)
            MODE_TOURNAMENT: f_final = f_cpick_local ? f_lpred : f_gpred;
            MODE_GLOBAL:     f_final = f_gpred;
            MODE_LOCAL:      f_final = f_lpred;
            default:         f_final = 1'b0;
        endcase
    end

    // Outputs are held quiet while reset is asserted.
    assign f_pred_taken = ~rst & f_final;
    assign f_meta       = rst ? '0 : {ghr_q, f_gpred, f_lpred, f_final};

    // ------------------------------------------------------------------
    // Resolution-side recompute (from the carried snapshot, not live GHR)
    // ------------------------------------------------------------------
    logic [GHR_W-1:0]      r_ghr_snap;
    logic                  r_gpred;
    logic                  r_lpred;
    logic                  r_fpred;
    logic [GPHT_IDX_W-1:0] r_g_idx;
    logic [LHT_IDX_W-1:0]  r_l_idx;
    logic [LHR_W-1:0]      r_lhist;
    logic [CPHT_IDX_W-1:0] r_c_idx;
    logic                  r_mispredict;

    assign r_ghr_snap = r_meta[META_W-1:3];
    assign r_gpred    = r_meta[META_GLOBAL];
    assign r_lpred    = r_meta[META_LOCAL];
    assign r_fpred    = r_meta[META_FINAL];

    assign r_g_idx = r_pc[GPHT_IDX_W+1:2] ^ GPHT_IDX_W'(r_ghr_snap);
    assign r_l_idx = r_pc[LHT_IDX_W+1:2];
    // Local PHT is trained at the history this branch sees before its own outcome is shifted in.
    assign r_lhist = lht_q[r_l_idx];
    assign r_c_idx = r_pc[CPHT_IDX_W+1:2];

    assign r_mispredict = r_valid & (r_taken != r_fpred);
    assign mispredict   = ~rst & r_mispredict;

    // Upper PC bits and the low byte-offset bits do not take part in any index.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc, r_pc};

    // ------------------------------------------------------------------
    // Next-state values for the single entry each table writes per cycle
    // ------------------------------------------------------------------
    ctr_t             gpht_d;
    ctr_t             lpht_d;
    ctr_t             cpht_d;
    logic             cpht_we;
    logic [LHR_W-1:0] lht_d;

    // Both direction tables train toward the actual outcome on every resolve.
    always_comb begin
        gpht_d = ctr_train(gpht_q[r_g_idx], r_taken);
        lpht_d = ctr_train(lpht_q[r_lhist], r_taken);
        lht_d  = {r_lhist[LHR_W-2:0], r_taken};
    end

    // Chooser only learns when the two components disagreed; up means "trust local".
    always_comb begin
        cpht_we = 1'b0;
        cpht_d  = cpht_q[r_c_idx];
        if (r_valid && (r_gpred != r_lpred)) begin
            cpht_we = 1'b1;
            cpht_d  = ctr_train(cpht_q[r_c_idx], r_lpred == r_taken);
        end
    end

    // GHR: repair from the snapshot on a mispredict, which also discards the
    // wrong-path D-stage shift; otherwise speculatively shift in D's prediction.
    always_comb begin
        ghr_d = ghr_q;
        if (r_mispredict) begin
            ghr_d = {r_ghr_snap[GHR_W-2:0], r_taken};
        end else if (d_branch) begin
            ghr_d = {ghr_q[GHR_W-2:0], d_pred_taken};
        end
    end

    // ------------------------------------------------------------------
    // Sequential state; every read above sees the pre-edge contents
    // ------------------------------------------------------------------

    // Global history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Global (gshare) pattern history table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < GPHT_N; i++) begin
                gpht_q[i] <= CTR_INIT;
            end
        end else if (r_valid) begin
            gpht_q[r_g_idx] <= gpht_d;
        end
    end

    // Local pattern history table, indexed by per-branch history.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LPHT_N; i++) begin
                lpht_q[i] <= CTR_INIT;
            end
        end else if (r_valid) begin
            lpht_q[r_lhist] <= lpht_d;
        end
    end

    // Local history table: non-speculative, updated only with resolved outcomes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LHT_N; i++) begin
                lht_q[i] <= '0;
            end
        end else if (r_valid) begin
            lht_q[r_l_idx] <= lht_d;
        end
    end

    // Chooser table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CPHT_N; i++) begin
                cpht_q[i] <= CTR_INIT;
            end
        end else if (cpht_we) begin
            cpht_q[r_c_idx] <= cpht_d;
        end
    end

endmodule

// File: tb/tb_tournament_bp.sv
// Bench for tournament_bp: scripted fetch/resolve traffic with a queue of expected outputs.
// Latency: expectations are queued as each cycle's stimulus is driven and drained mid-cycle.
// Backpressure: not applicable; the DUT accepts one lookup and one resolve every cycle.
module tb_tournament_bp;

    localparam int GHR_W  = 8;
    localparam int META_W = GHR_W + 3;

    localparam int S_PRED = 0;
    localparam int S_META = 1;
    localparam int S_MISP = 2;
    localparam int S_GHR  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic [31:0]       f_pc;
    logic              f_pred_taken;
    logic [META_W-1:0] f_meta;
    logic              d_branch;
    logic              d_pred_taken;
    logic              r_valid;
    logic [31:0]       r_pc;
    logic              r_taken;
    logic [META_W-1:0] r_meta;
    logic              mispredict;

    int checks   = 0;
    int failures = 0;

    string       tag_q [$];
    int          sel_q [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    tournament_bp dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .f_pc         (f_pc),
        .f_pred_taken (f_pred_taken),
        .f_meta       (f_meta),
        .d_branch     (d_branch),
        .d_pred_taken (d_pred_taken),
        .r_valid      (r_valid),
        .r_pc         (r_pc),
        .r_taken      (r_taken),
        .r_meta       (r_meta),
        .mispredict   (mispredict)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_PRED:  return {31'b0, f_pred_taken};
            S_META:  return 32'(f_meta);
            S_MISP:  return {31'b0, mispredict};
            default: return 32'(f_meta[META_W-1:3]);
        endcase
    endfunction

    // Let combinational outputs settle, then compare everything queued this cycle.
    task automatic drain();
        string       t;
        int          s;
        logic [31:0] e;
        #2;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            check_eq(t, observe(s), e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_branch     = 1'b0;
        d_pred_taken = 1'b0;
        r_valid      = 1'b0;
        r_pc         = 32'h0;
        r_taken      = 1'b0;
        r_meta       = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [META_W-1:0] m);
        r_valid = 1'b1;
        r_pc    = pc;
        r_taken = tk;
        r_meta  = m;
    endtask

    function automatic logic [META_W-1:0] mk_meta(input logic [7:0] g, input logic gp,
                                                  input logic lp, input logic fp);
        return {g, gp, lp, fp};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]        pat;
        logic [META_W-1:0] m;

        // Reset held with a conflicting resolve on the bus: outputs must stay quiet.
        rst  = 1'b1;
        mode = 2'b00;
        f_pc = 32'h0040_0010;
        idle();
        resolve(32'h0040_0010, 1'b0, mk_meta(8'h00, 1'b1, 1'b1, 1'b1));
        repeat (3) @(posedge clk);
        #1;
        expect_out("rst_pred", S_PRED, 32'h0);
        expect_out("rst_meta", S_META, 32'h0);
        expect_out("rst_misp", S_MISP, 32'h0);
        drain();

        // Fresh tables: weakly not-taken everywhere.
        tick();
        rst = 1'b0;
        idle();
        expect_out("init_pred", S_PRED, 32'h0);
        expect_out("init_meta", S_META, 32'h0);
        drain();

        // Two taken resolves of 0x..10 with all-zero metadata.
        tick();
        resolve(32'h0040_0010, 1'b1, '0);
        expect_out("train1_misp", S_MISP, 32'h1);
        drain();
        tick();
        resolve(32'h0040_0010, 1'b1, '0);
        expect_out("train2_misp", S_MISP, 32'h1);
        expect_out("train2_meta", S_META, 32'h08);
        drain();

        // GHR is now 1; PC 0x..14 aligns g_idx onto the trained entry 0x04.
        tick();
        idle();
        f_pc = 32'h0040_0014;
        expect_out("aligned_pred", S_PRED, 32'h1);
        expect_out("aligned_meta", S_META, 32'h0F);
        drain();
        tick();
        f_pc = 32'h0040_0010;
        expect_out("unaligned_pred", S_PRED, 32'h0);
        expect_out("unaligned_meta", S_META, 32'h08);
        drain();

        // Chooser on c_idx 0x05: three local-right pulls, one agreeing resolve,
        // then two global-right pulls. F on 0x..14 has global=1, local=0 after the first.
        f_pc = 32'h0040_0014;
        tick();
        resolve(32'h0040_0014, 1'b0, mk_meta(8'h77, 1'b1, 1'b0, 1'b0));
        expect_out("ch_inc1_pred", S_PRED, 32'h1);
        expect_out("ch_inc1_misp", S_MISP, 32'h0);
        drain();
        tick();
        expect_out("ch_inc2_pred", S_PRED, 32'h0);
        expect_out("ch_inc2_meta", S_META, 32'h0C);
        drain();
        tick();
        expect_out("ch_inc3_pred", S_PRED, 32'h0);
        drain();
        tick();
        resolve(32'h0040_0014, 1'b0, mk_meta(8'h77, 1'b0, 1'b0, 1'b0));
        expect_out("ch_sat_pred", S_PRED, 32'h0);
        drain();
        tick();
        resolve(32'h0040_0014, 1'b0, mk_meta(8'h77, 1'b0, 1'b1, 1'b0));
        expect_out("ch_equal_pred", S_PRED, 32'h0);
        drain();
        tick();
        expect_out("ch_dec1_pred", S_PRED, 32'h0);
        drain();
        tick();
        idle();
        expect_out("ch_dec2_pred", S_PRED, 32'h1);
        expect_out("ch_dec2_meta", S_META, 32'h0D);
        drain();

        // Speculative shift of 0x5A into the GHR, MSB first.
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            tick();
            d_branch     = 1'b1;
            d_pred_taken = pat[7-i];
            if (i == 4) begin
                expect_out("ghr_half", S_GHR, 32'h15);
            end
            drain();
        end

        // Mispredict with a same-cycle D branch: repair from snapshot, shift dropped.
        tick();
        d_branch     = 1'b1;
        d_pred_taken = 1'b1;
        resolve(32'h0040_0200, 1'b0, mk_meta(8'h2C, 1'b1, 1'b1, 1'b1));
        expect_out("rec_ghr_pre", S_GHR, 32'h5A);
        expect_out("rec_misp", S_MISP, 32'h1);
        drain();
        tick();
        idle();
        expect_out("rec_ghr_post", S_GHR, 32'h58);
        drain();

        // PC 0x..170 with GHR 0x58 lands on the trained-taken global entry.
        f_pc = 32'h0040_0170;
        mode = 2'b11;
        tick();
        expect_out("static_pred", S_PRED, 32'h0);
        expect_out("static_meta", S_META, 32'h2C4);
        drain();
        tick();
        mode = 2'b01;
        expect_out("global_pred", S_PRED, 32'h1);
        expect_out("global_meta", S_META, 32'h2C5);
        drain();
        tick();
        mode = 2'b10;
        expect_out("local_pred", S_PRED, 32'h0);
        drain();
        tick();
        mode = 2'b00;
        expect_out("tourn_pred", S_PRED, 32'h1);
        drain();

        // Alternating branch, local-only: history must learn the pattern.
        mode = 2'b10;
        for (int i = 0; i < 40; i++) begin
            tick();
            idle();
            f_pc = 32'h0040_0020;
            #1;
            m = f_meta;
            resolve(32'h0040_0020, (i % 2) == 0, m);
            if (i == 0) begin
                expect_out("alt_first_misp", S_MISP, 32'h1);
            end
            if (i >= 24) begin
                expect_out($sformatf("alt_misp_%0d", i), S_MISP, 32'h0);
            end
            drain();
        end

        // Reset in the middle of traffic.
        tick();
        rst  = 1'b1;
        mode = 2'b01;
        f_pc = 32'h0040_0170;
        resolve(32'h0040_0010, 1'b0, mk_meta(8'hFF, 1'b1, 1'b1, 1'b1));
        expect_out("midrst_pred", S_PRED, 32'h0);
        expect_out("midrst_meta", S_META, 32'h0);
        expect_out("midrst_misp", S_MISP, 32'h0);
        drain();
        tick();
        rst = 1'b0;
        idle();
        resolve(32'h0040_0300, 1'b0, '0);
        expect_out("postrst_pred", S_PRED, 32'h0);
        expect_out("postrst_meta", S_META, 32'h0);
        expect_out("postrst_misp", S_MISP, 32'h0);
        drain();
        tick();
        idle();
        mode = 2'b00;
        f_pc = 32'h0040_0014;
        expect_out("postrst_pc14_pred", S_PRED, 32'h0);
        expect_out("postrst_pc14_meta", S_META, 32'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tournament_bp.md
Name: tournament_bp

Overview:
- Parametrised tournament branch-direction predictor for the 5-stage MIPS pipeline.
- Combines three tables:
  - a gshare global predictor (PC XOR speculative GHR);
  - a two-level local predictor (per-PC local history indexing a local PHT);
  - a 2-bit chooser table.
- Predicts in F, speculatively shifts GHR in D, trains and repairs at resolution in M.
- Per-branch metadata travels down the pipeline with the branch.

Parameters:
- GPHT_IDX_W, 8, log2 entries of global PHT
- GHR_W, 8, global history bits (≤ GPHT_IDX_W)
- LHT_IDX_W, 4, log2 entries of local history table
- LHR_W, 6, local history bits; local PHT has 2^LHR_W entries
- CPHT_IDX_W, 8, log2 entries of chooser table
- META_W, GHR_W+3, metadata width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mode  in  2  00 tournament, 01 global-only, 10 local-only, 11 static not-taken
- f_pc  in  32  fetch PC
- f_pred_taken  out  1  predicted direction for f_pc
- f_meta  out  META_W  {ghr_snapshot, global_pred, local_pred, final_pred}
- d_branch  in  1  instruction in D is a conditional branch
- d_pred_taken  in  1  final prediction carried with D instruction
- r_valid  in  1  branch resolved in M this cycle
- r_pc  in  32  PC of resolving branch
- r_taken  in  1  actual direction
- r_meta  in  META_W  metadata carried with resolving branch
- mispredict  out  1  final prediction wrong (drives flush of younger stages)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All global PHT, local PHT and chooser counters reset to 2'b01.
  - All LHT entries reset to 0; GHR resets to 0.
  - While rst is high, f_pred_taken=0, f_meta=0 and mispredict=0.
- Indexing (F, combinational):
  - g_idx = f_pc[GPHT_IDX_W+1:2] XOR zero-extended GHR.
  - l_idx = f_pc[LHT_IDX_W+1:2]; the local PHT index is LHT[l_idx].
  - c_idx = f_pc[CPHT_IDX_W+1:2].
- Prediction (zero latency):
  - global_pred and local_pred are the MSBs of their counters.
  - final_pred by mode: chooser MSB 1 selects local, 0 selects global (mode 00); global_pred (01); local_pred (10); 0 (11).
  - f_meta snapshots the current GHR together with all three prediction bits.
- Speculative history (D):
  - When d_branch=1 and no recovery occurs this cycle: GHR <= {GHR[GHR_W-2:0], d_pred_taken} at the edge.
- Resolution (M, r_valid=1):
  - mispredict = r_valid & (r_taken != r_meta.final_pred), combinational.
  - Indices are recomputed from r_pc and r_meta.ghr_snapshot (not the current GHR).
  - Global PHT and local PHT counters each train toward r_taken, saturating at 00 and 11.
  - LHT[r_pc idx] <= {old[LHR_W-2:0], r_taken}. This is non-speculative; the local PHT index uses the pre-update LHT value.
  - Chooser updates only when global_pred != local_pred: increment (sat 11) if local was correct, decrement (sat 00) if global was correct.
  - Training happens in all modes, including 11.
- Recovery: on mispredict, GHR <= {r_meta.ghr_snapshot[GHR_W-2:0], r_taken}.
- Simultaneous events:
  - Recovery overrides a same-cycle d_branch shift, because the D instruction is wrong-path.
  - A same-cycle F read and M write to the same entry: F sees the pre-edge value.
  - rst overrides everything.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight metadata is ignored because r_valid must be deasserted by the pipeline flush.
- No internal pipeline registers for metadata; the pipeline carries f_meta through D/E/M.

Test Plan:
- Reset then f_pc=0x00400010, mode=00 -> f_pred_taken=0, f_meta=0; after 2 taken resolves of the same PC with matching meta, global counter reaches 11, prediction=1 (GHR-aligned).
- Alternating T/N/T/N branch at 0x00400020, 40 resolves, mode=10 -> local history learns it; zero mispredicts over the last 16 resolves.
- Mispredict: GHR=0x5A, r_meta.ghr_snapshot=0x2C, final_pred=1, r_taken=0, d_branch=1 same cycle -> mispredict=1, next GHR=0x58 (d_branch shift suppressed).
- Chooser: global wrong and local right 3 times on one c_idx -> chooser goes 01→10→11→11 (saturates); equal predictions leave it unchanged.
- mode=11 with trained-taken tables -> f_pred_taken=0, final_pred bit 0; mode=01 on the same PC -> 1.
- rst asserted mid-stream after training -> next cycle all predictions 0, GHR=0, mispredict=0.
